// File: rtl/cdc_vector_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdc_vector_arbiter_if
//   Bundles the requester-side AXI-stream bus and the downstream CDC channel
//   handshake of cdc_vector_arbiter.
//
// Handshake rule (both sides): a word moves on a clock edge where valid and
// ready are both high. Once valid is raised it stays high, with data stable,
// until that edge. Ready may be raised or lowered freely.
//
// Signals
//   s_tvalid [N]          requester -> arbiter, per-requester valid
//   s_tready [N]          arbiter -> requester, at most one bit high
//   s_tdata  [N*WIDTH]    requester k payload at [k*WIDTH +: WIDTH]
//   m_tvalid              arbiter -> CDC channel
//   m_tready              CDC channel -> arbiter
//   m_tdata  [IDW+WIDTH]  {tag, payload}, tag in the MSBs
//
// Modports
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus channel)
// -----------------------------------------------------------------------------
interface cdc_vector_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]         s_tvalid;
  logic [N-1:0]         s_tready;
  logic [N*WIDTH-1:0]   s_tdata;
  logic                 m_tvalid;
  logic                 m_tready;
  logic [IDW+WIDTH-1:0] m_tdata;

  modport slave (
    input  s_tvalid, s_tdata, m_tready,
    output s_tready, m_tvalid, m_tdata
  );

  modport master (
    output s_tvalid, s_tdata, m_tready,
    input  s_tready, m_tvalid, m_tdata
  );
endinterface

// File: rtl/cdc_vector_arbiter.sv
// -----------------------------------------------------------------------------
// cdc_vector_arbiter
//   Round-robin arbiter that shares one CDC vector channel among N
//   AXI-stream requesters. It takes one word from the winner, tags it with the
//   requester index, presents {tag, payload} downstream, and waits for the
//   channel to raise m_tready again (the delivery ack) before it grants again.
//
// Ports
//   clk          single clock, all logic on posedge
//   aresetn      asynchronous active-low reset
//   bus          cdc_vector_arbiter_if.slave (s_* requesters, m_* channel)
//   busy         high whenever the FSM is not IDLE
//   grant_id     tag of the word currently held or in flight
//   xfer_count   completed downstream handshakes, wraps 0xFFFF -> 0
//   timeout      sticky flag: ack not seen within TIMEOUT_CYCLES in WAIT_ACK
//   timeout_clr  synchronous clear of timeout (a same-cycle set wins)
//   dbg_state    current FSM state (0 IDLE, 1 SEND, 2 WAIT_ACK)
// -----------------------------------------------------------------------------
module cdc_vector_arbiter #(
  parameter int N              = 4,
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDW           = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 aresetn,
  cdc_vector_arbiter_if.slave  bus,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic [15:0]          xfer_count,
  output logic                 timeout,
  input  logic                 timeout_clr,
  output logic [1:0]           dbg_state
);

  localparam int IW = IDW + 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t               r_state;
  logic [IDW-1:0]       r_rr_ptr;
  logic [IDW-1:0]       r_grant_id;
  logic [IDW+WIDTH-1:0] r_hold;
  logic                 r_m_tvalid;
  logic [15:0]          r_xfer_count;
  logic [CW-1:0]        r_ack_cnt;
  logic                 r_timeout;

  logic                 w_found;
  logic [IDW-1:0]       w_win;
  logic [IW-1:0]        w_idx;
  logic [WIDTH-1:0]     w_payload;
  logic [N-1:0]         w_s_tready;
  logic [IDW-1:0]       w_next_ptr;
  logic [CW-1:0]        w_cnt_inc;
  logic                 w_timeout_set;

  // Search rr_ptr, rr_ptr+1, ... wrapping mod N; the first valid requester
  // wins. The running index never exceeds 2N-2, so one conditional subtract
  // performs the wrap, which also keeps non-power-of-2 N correct.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = {1'b0, r_rr_ptr} + IW'(i);
      if (w_idx >= IW'(N)) begin
        w_idx = w_idx - IW'(N);
      end
      if (!w_found && bus.s_tvalid[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    w_payload = '0;
    for (int k = 0; k < N; k++) begin
      if (w_win == IDW'(k)) begin
        w_payload = bus.s_tdata[k*WIDTH +: WIDTH];
      end
    end
  end

  // Ready goes only to the winner and only while IDLE. The winner's valid is
  // high by construction, so w_found in IDLE is exactly the capture handshake.
  always_comb begin
    w_s_tready = '0;
    if (aresetn && (r_state == IDLE) && w_found) begin
      w_s_tready[w_win] = 1'b1;
    end
  end

  assign w_next_ptr = (w_win == IDW'(N - 1)) ? '0 : (w_win + IDW'(1));
  assign w_cnt_inc  = r_ack_cnt + CW'(1);

  // The flag sets on the edge where the saturating ack counter reaches the
  // limit; once saturated it never re-fires, so a later clear sticks.
  assign w_timeout_set = (r_state == WAIT_ACK) && (r_ack_cnt != TO_MAX) &&
                         (w_cnt_inc == TO_MAX);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_grant_id   <= '0;
      r_hold       <= '0;
      r_m_tvalid   <= 1'b0;
      r_xfer_count <= '0;
      r_ack_cnt    <= '0;
      r_timeout    <= 1'b0;
    end else begin
      if (w_timeout_set) begin
        r_timeout <= 1'b1;
      end else if (timeout_clr) begin
        r_timeout <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_hold     <= {w_win, w_payload};
            r_grant_id <= w_win;
            r_rr_ptr   <= w_next_ptr;
            r_m_tvalid <= 1'b1;
            r_state    <= SEND;
          end
        end
        SEND: begin
          // m_tvalid is always high here, so m_tready alone is the handshake.
          if (bus.m_tready) begin
            r_m_tvalid   <= 1'b0;
            r_xfer_count <= r_xfer_count + 16'd1;
            r_ack_cnt    <= '0;
            r_state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (r_ack_cnt != TO_MAX) begin
            r_ack_cnt <= w_cnt_inc;
          end
          // m_tready returning high means the channel delivered the word.
          if (bus.m_tready) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.s_tready = w_s_tready;
  assign bus.m_tvalid = r_m_tvalid;
  assign bus.m_tdata  = r_hold;
  assign busy         = (r_state != IDLE);
  assign grant_id     = r_grant_id;
  assign xfer_count   = r_xfer_count;
  assign timeout      = r_timeout;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_cdc_vector_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdc_vector_arbiter
//   Directed bench for cdc_vector_arbiter (N=4, WIDTH=8, TIMEOUT_CYCLES=8).
//   Inputs are driven 1 time unit after posedge; outputs are sampled 3 time
//   units after posedge. A monitor pops expected words from exp_q on every
//   downstream handshake.
// -----------------------------------------------------------------------------
module tb_cdc_vector_arbiter;
  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  // clock / reset
  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  logic             timeout_clr;
  logic             busy;
  logic [IDW-1:0]   grant_id;
  logic [15:0]      xfer_count;
  logic             timeout;
  logic [1:0]       dbg_state;

  cdc_vector_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();

  cdc_vector_arbiter #(
    .N(N), .WIDTH(WIDTH), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .bus        (bus),
    .busy       (busy),
    .grant_id   (grant_id),
    .xfer_count (xfer_count),
    .timeout    (timeout),
    .timeout_clr(timeout_clr),
    .dbg_state  (dbg_state)
  );

  // scoreboard
  logic [IDW+WIDTH-1:0] exp_q[$];
  logic [31:0]          lanes = 32'hD3C2_B1A5;
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #3;
    if (aresetn && bus.m_tvalid && bus.m_tready) begin
      chk("sb_word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("sb_m_tdata", 32'(bus.m_tdata), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    aresetn      = 1'b0;
    bus.s_tvalid = '0;
    bus.s_tdata  = lanes;
    bus.m_tready = 1'b0;
    timeout_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    chk("rst_s_tready", 32'(bus.s_tready), 32'd0);
    chk("rst_m_tdata", 32'(bus.m_tdata), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_xfer_count", 32'(xfer_count), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
  endtask

  // Called in an IDLE cycle where `tag` is the expected winner. The channel
  // holds m_tready low for `stall` SEND cycles, then accepts, then acks on the
  // `ack_delay`-th WAIT_ACK cycle. Returns in the following IDLE cycle.
  task automatic serve(input int tag, input int stall, input int ack_delay);
    logic [IDW+WIDTH-1:0] exp_word;
    logic [N-1:0]         onehot;
    exp_word = {IDW'(tag), lanes[tag*WIDTH +: WIDTH]};
    onehot   = '0;
    onehot[tag] = 1'b1;
    bus.m_tready = 1'b0;
    #2;
    chk("idle_s_tready", 32'(bus.s_tready), 32'(onehot));
    chk("idle_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    exp_q.push_back(exp_word);
    tick();
    for (int c = 0; c < stall; c++) begin
      bus.m_tready = 1'b0;
      #2;
      chk("stall_m_tvalid", 32'(bus.m_tvalid), 32'd1);
      chk("stall_m_tdata", 32'(bus.m_tdata), 32'(exp_word));
      tick();
    end
    bus.m_tready = 1'b1;
    #2;
    chk("send_m_tvalid", 32'(bus.m_tvalid), 32'd1);
    chk("send_m_tdata", 32'(bus.m_tdata), 32'(exp_word));
    chk("send_grant_id", 32'(grant_id), 32'(tag));
    chk("send_s_tready", 32'(bus.s_tready), 32'd0);
    tick();
    for (int c = 1; c < ack_delay; c++) begin
      bus.m_tready = 1'b0;
      #2;
      chk("wait_m_tvalid", 32'(bus.m_tvalid), 32'd0);
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_s_tready", 32'(bus.s_tready), 32'd0);
      tick();
    end
    bus.m_tready = 1'b1;
    #2;
    chk("ack_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    chk("ack_dbg_state", 32'(dbg_state), 32'd2);
    tick();
  endtask

  initial begin
    aresetn      = 1'b0;
    bus.s_tvalid = '0;
    bus.s_tdata  = lanes;
    bus.m_tready = 1'b0;
    timeout_clr  = 1'b0;

    // Single request, channel always ready.
    do_reset();
    bus.s_tvalid = 4'b0001;
    serve(0, 0, 1);
    bus.s_tvalid = '0;
    #2;
    chk("t1_xfer_count", 32'(xfer_count), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);

    // All four requesting, ack five cycles after acceptance.
    do_reset();
    bus.s_tvalid = 4'b1111;
    serve(0, 0, 5);
    serve(1, 0, 5);
    serve(2, 0, 5);
    serve(3, 0, 5);
    serve(0, 0, 5);
    bus.s_tvalid = '0;
    #2;
    chk("t2_xfer_count", 32'(xfer_count), 32'd5);

    // Move rr_ptr to 2, then requesters 1 and 3: 3 wins first, then 1.
    do_reset();
    bus.s_tvalid = 4'b0010;
    serve(1, 0, 1);
    bus.s_tvalid = 4'b1010;
    serve(3, 0, 2);
    serve(1, 0, 2);
    bus.s_tvalid = '0;
    #2;
    chk("t3_xfer_count", 32'(xfer_count), 32'd3);

    // Channel stalls ten cycles in SEND; accepted on the eleventh.
    do_reset();
    bus.s_tvalid = 4'b0100;
    serve(2, 10, 3);
    bus.s_tvalid = '0;
    #2;
    chk("t4_xfer_count", 32'(xfer_count), 32'd1);

    // Ack never comes: timeout after 8 WAIT_ACK cycles. A clear issued on the
    // setting edge loses to the set.
    do_reset();
    bus.s_tvalid = 4'b0100;
    exp_q.push_back({2'd2, lanes[23:16]});
    #2;
    chk("to_s_tready", 32'(bus.s_tready), 32'h4);
    tick();
    bus.s_tvalid = '0;
    bus.m_tready = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      bus.m_tready = 1'b0;
      timeout_clr  = (c == 8);
      #2;
      chk("to_not_yet", 32'(timeout), 32'd0);
      tick();
    end
    timeout_clr = 1'b0;
    #2;
    chk("to_set", 32'(timeout), 32'd1);
    chk("to_busy", 32'(busy), 32'd1);
    chk("to_state", 32'(dbg_state), 32'd2);
    repeat (3) tick();
    #2;
    chk("to_still_waiting", 32'(dbg_state), 32'd2);
    chk("to_sticky", 32'(timeout), 32'd1);
    tick();
    bus.m_tready = 1'b1;
    tick();
    bus.m_tready = 1'b0;
    #2;
    chk("to_idle_busy", 32'(busy), 32'd0);
    chk("to_idle_flag", 32'(timeout), 32'd1);
    tick();
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    #2;
    chk("to_cleared", 32'(timeout), 32'd0);

    // Reset while SEND holds a word: word dropped, never re-sent.
    do_reset();
    bus.s_tvalid = 4'b0100;
    tick();
    bus.s_tvalid = '0;
    bus.m_tready = 1'b0;
    #2;
    chk("mid_send_valid", 32'(bus.m_tvalid), 32'd1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_m_tdata", 32'(bus.m_tdata), 32'd0);
    tick();
    aresetn      = 1'b1;
    bus.m_tready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk("mid_no_resend", 32'(bus.m_tvalid), 32'd0);
      tick();
    end
    bus.m_tready = 1'b0;

    // xfer_count wrap from 0xFFFF.
    do_reset();
    force dut.r_xfer_count = 16'hFFFF;
    tick();
    release dut.r_xfer_count;
    #2;
    chk("wrap_preset", 32'(xfer_count), 32'hFFFF);
    tick();
    bus.s_tvalid = 4'b0001;
    serve(0, 0, 1);
    bus.s_tvalid = '0;
    #2;
    chk("wrap_zero", 32'(xfer_count), 32'd0);

    repeat (3) tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
